// File: rtl/ram_arb_pkg.sv
// Shared types and width helpers for the RAM port arbiter and its picker.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RDATA = 2'd2
    } arb_state_e;

    function automatic int unsigned addr_width(input int unsigned length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

    function automatic int unsigned byte_enables(input int unsigned width, input int unsigned lane);
        return width / lane;
    endfunction

    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin / fixed-priority picker: first asserted req after ptr wins,
// or the lowest asserted index when fixed_prio is set.
module rr_priority_picker
    import ram_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = index_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed_prio,
    output logic [N_REQ-1:0] win_onehot_c,
    output logic [IDX_W-1:0] win_idx_c,
    output logic             win_valid_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot_c = '0;
        win_idx_c    = '0;
        win_valid_c  = 1'b0;
        cand         = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = fixed_prio ? IDX_W'(k) : IDX_W'((32'(ptr) + 32'd1 + k) % N_REQ);
            if (!win_valid_c && req[cand]) begin
                win_valid_c        = 1'b1;
                win_idx_c          = cand;
                win_onehot_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port byte-enabled synchronous RAM among N_REQ requesters.
// Define RAM_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round robin.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int unsigned N_REQ                   = 4,
    parameter  int unsigned LENGTH                  = 32'h1000,
    parameter  int unsigned WIDTH                   = 32,
    parameter  int unsigned MINIMUM_SECTIONAL_WIDTH = 8,
    localparam int unsigned ADDRESS_WIDTH           = addr_width(LENGTH),
    localparam int unsigned BYTE_ENABLES            = byte_enables(WIDTH, MINIMUM_SECTIONAL_WIDTH),
    localparam int unsigned IDX_W                   = index_width(N_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req,
    input  logic [N_REQ*BYTE_ENABLES-1:0]   req_we,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [N_REQ*WIDTH-1:0]          req_wdata,
    output logic [N_REQ-1:0]                gnt,
    output logic [N_REQ-1:0]                rvalid,
    output logic [WIDTH-1:0]                rdata,
    output logic                            busy,
    output logic                            mem_cs,
    output logic                            mem_oe,
    output logic [BYTE_ENABLES-1:0]         mem_we,
    output logic [ADDRESS_WIDTH-1:0]        mem_addr,
    output logic [WIDTH-1:0]                mem_wdata,
    input  logic [WIDTH-1:0]                mem_rdata
);

`ifdef RAM_ARB_FIXED_PRIORITY_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [N_REQ-1:0]         gnt_d, rvalid_d;
    logic [WIDTH-1:0]         rdata_d, mem_wdata_d;
    logic                     busy_d, mem_cs_d, mem_oe_d;
    logic [BYTE_ENABLES-1:0]  mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_d;

    logic [N_REQ-1:0] win_onehot_c;
    logic [IDX_W-1:0] win_idx_c;
    logic             win_valid_c;

    logic [BYTE_ENABLES-1:0]  we_arr    [N_REQ];
    logic [ADDRESS_WIDTH-1:0] addr_arr  [N_REQ];
    logic [WIDTH-1:0]         wdata_arr [N_REQ];

    // Split the flat per-requester command buses into indexable slices
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign we_arr[g]    = req_we[g*BYTE_ENABLES +: BYTE_ENABLES];
        assign addr_arr[g]  = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign wdata_arr[g] = req_wdata[g*WIDTH +: WIDTH];
    end

    rr_priority_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req          (req),
        .ptr          (ptr_q),
        .fixed_prio   (FIXED_PRIO),
        .win_onehot_c (win_onehot_c),
        .win_idx_c    (win_idx_c),
        .win_valid_c  (win_valid_c)
    );

    // Next-state and next-output logic; every output is the registered copy of its _d
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata;
        mem_cs_d    = 1'b0;
        mem_oe_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid_c) begin
                    state_d     = ARB_ISSUE;
                    gnt_d       = win_onehot_c;
                    ptr_d       = win_idx_c;
                    owner_d     = win_idx_c;
                    mem_cs_d    = 1'b1;
                    mem_oe_d    = (we_arr[win_idx_c] == '0);
                    mem_we_d    = we_arr[win_idx_c];
                    mem_addr_d  = addr_arr[win_idx_c];
                    mem_wdata_d = wdata_arr[win_idx_c];
                end
            end
            ARB_ISSUE: begin
                // RAM acts on the edge closing this cycle; reads need one more cycle for data
                state_d = mem_oe ? ARB_RDATA : ARB_IDLE;
            end
            ARB_RDATA: begin
                rdata_d  = mem_rdata;
                rvalid_d = N_REQ'(1) << owner_q;
                state_d  = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            owner_q   <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt       <= gnt_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            busy      <= busy_d;
            mem_cs    <= mem_cs_d;
            mem_oe    <= mem_oe_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule
